// File: rtl/sounder_sequencer_pkg.sv
// Register map, mode masks, state encoding and command helpers shared by the sounder sequencer.
package sounder_sequencer_pkg;

   localparam logic [6:0]  FR_MODE           = 7'd64;
   localparam logic [6:0]  FR_DEGREE         = 7'd65;
   localparam logic [6:0]  FR_AMPL           = 7'd66;

   localparam logic [31:0] BM_FR_MODE_RESET  = 32'h0000_0001;
   localparam logic [31:0] BM_FR_MODE_TX     = 32'h0000_0002;
   localparam logic [31:0] BM_FR_MODE_RX     = 32'h0000_0004;
   localparam logic [31:0] BM_FR_MODE_LP     = 32'h0000_0008;

   typedef enum logic [3:0] {
      ST_IDLE, ST_WR_RST, ST_WR_DEG, ST_WR_AMPL, ST_WR_MODE,
      ST_WR_RUN, ST_RUN, ST_WR_STOP, ST_DONE
   } state_e;

   // mode is {lp,rx,tx}
   function automatic logic [31:0] mode_bits(input logic [2:0] mode);
      mode_bits = (mode[0] ? BM_FR_MODE_TX : 32'd0) |
                  (mode[1] ? BM_FR_MODE_RX : 32'd0) |
                  (mode[2] ? BM_FR_MODE_LP : 32'd0);
   endfunction

   function automatic logic cmd_legal(input logic [5:0] deg, input logic [2:0] mode);
      cmd_legal = (deg >= 6'd2) && (deg <= 6'd16) && (mode[1:0] != 2'b00);
   endfunction

   function automatic logic is_wr_state(input state_e s);
      case (s)
         ST_WR_RST, ST_WR_DEG, ST_WR_AMPL, ST_WR_MODE, ST_WR_RUN, ST_WR_STOP: is_wr_state = 1'b1;
         default: is_wr_state = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sounder_sequencer_if.sv
// Serial configuration bus from the sequencer to the sounder core.
interface sounder_sequencer_if;
   logic [6:0]  saddr;
   logic [31:0] sdata;
   logic        s_strobe;

   modport master (output saddr, output sdata, output s_strobe);
   modport slave  (input saddr, input sdata, input s_strobe);
endinterface

// File: rtl/sounder_cfg_writer.sv
// Issues one config write: a 1-cycle strobe, then WR_GAP idle cycles; ack marks the last
// cycle of the write so a back-to-back request is accepted on the same edge.
module sounder_cfg_writer #(
   parameter int unsigned WR_GAP = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [6:0]  addr_i,
   input  logic [31:0] data_i,
   output logic        ack_o,
   sounder_sequencer_if.master cfg
);
   localparam logic [3:0] GAP = 4'(WR_GAP);

   logic        busy_q, busy_d;
   logic        strobe_q, strobe_d;
   logic [3:0]  gap_q, gap_d;
   logic [6:0]  saddr_q, saddr_d;
   logic [31:0] sdata_q, sdata_d;

   assign ack_o        = busy_q && (gap_q == 4'd0);
   assign cfg.saddr    = saddr_q;
   assign cfg.sdata    = sdata_q;
   assign cfg.s_strobe = strobe_q;

   // accept a request when free or finishing, otherwise count down the gap
   always_comb begin
      busy_d   = busy_q;
      strobe_d = 1'b0;
      gap_d    = gap_q;
      saddr_d  = saddr_q;
      sdata_d  = sdata_q;
      if (req_i && (!busy_q || ack_o)) begin
         busy_d   = 1'b1;
         strobe_d = 1'b1;
         gap_d    = GAP;
         saddr_d  = addr_i;
         sdata_d  = data_i;
      end else if (busy_q) begin
         if (gap_q == 4'd0) begin
            busy_d = 1'b0;
         end else begin
            gap_d = gap_q - 4'd1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // writer state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
         gap_q    <= 4'd0;
         saddr_q  <= 7'd0;
         sdata_q  <= 32'd0;
      end else begin
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
         gap_q    <= gap_d;
         saddr_q  <= saddr_d;
         sdata_q  <= sdata_d;
      end
   end
endmodule

// File: rtl/sounder_sequencer.sv
// Run-control master: programs the sounder core, counts PN sweeps, parks it in reset.
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN.
module sounder_sequencer
   import sounder_sequencer_pkg::*;
#(
   parameter int unsigned WR_GAP  = 2,
   parameter int unsigned CNT_W   = 16
`ifdef SEQ_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT = 65535
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [5:0]       degree_i,
   input  logic [13:0]      ampl_i,
   input  logic [2:0]       mode_i,
   input  logic [CNT_W-1:0] nsweeps_i,
   input  logic             tx_strobe_i,
   input  logic             rx_strobe_i,
   sounder_sequencer_if.master cfg,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] sweep_cnt_o
);
   state_e           state_q, state_d;
   logic [5:0]       deg_q, deg_d;
   logic [13:0]      ampl_q, ampl_d;
   logic [2:0]       mode_q, mode_d;
   logic [CNT_W-1:0] nsw_q, nsw_d;
   logic [CNT_W-1:0] sweep_q, sweep_d;
   logic [CNT_W-1:0] strb_q, strb_d;
   logic             err_q, err_d, busy_q, busy_d, done_q, done_d;
   logic             req_s, wr_ack_s, sel_strobe_s;
   logic [16:0]      sweep_last_s;
   logic [6:0]       addr_s;
   logic [31:0]      data_s;
`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

   assign sel_strobe_s = mode_q[1] ? rx_strobe_i : tx_strobe_i;
   assign sweep_last_s = (17'd1 << deg_q[4:0]) - 17'd2;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign sweep_cnt_o  = sweep_q;

   // sequencing FSM next state and run counters; a write state advances only on writer ack
   always_comb begin
      state_d = state_q;
      deg_d   = deg_q;
      ampl_d  = ampl_q;
      mode_d  = mode_q;
      nsw_d   = nsw_q;
      sweep_d = sweep_q;
      strb_d  = strb_q;
      err_d   = err_q;
`ifdef SEQ_TIMEOUT_EN
      wdog_d  = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               deg_d   = degree_i;
               ampl_d  = ampl_i;
               mode_d  = mode_i;
               nsw_d   = nsweeps_i;
               sweep_d = '0;
               strb_d  = '0;
               err_d   = !cmd_legal(degree_i, mode_i);
               state_d = cmd_legal(degree_i, mode_i) ? ST_WR_RST : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_RST:  if (wr_ack_s) state_d = abort_i ? ST_WR_STOP : ST_WR_DEG;  else state_d = state_q;
         ST_WR_DEG:  if (wr_ack_s) state_d = abort_i ? ST_WR_STOP : ST_WR_AMPL; else state_d = state_q;
         ST_WR_AMPL: if (wr_ack_s) state_d = abort_i ? ST_WR_STOP : ST_WR_MODE; else state_d = state_q;
         ST_WR_MODE: begin
            if (wr_ack_s) begin
               state_d = (abort_i || (nsw_q == '0)) ? ST_WR_STOP : ST_WR_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_WR_RUN:  if (wr_ack_s) state_d = abort_i ? ST_WR_STOP : ST_RUN; else state_d = state_q;
         ST_RUN: begin
            if (sel_strobe_s) begin
               if (strb_q == CNT_W'(sweep_last_s)) begin
                  strb_d  = '0;
                  sweep_d = sweep_q + 1'b1;
               end else begin
                  strb_d  = strb_q + 1'b1;
               end
            end else begin
`ifdef SEQ_TIMEOUT_EN
               if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                  err_d = 1'b1;
               end else begin
                  wdog_d = wdog_q + 1'b1;
               end
`else
               strb_d = strb_q;
`endif
            end
            if (abort_i || (sweep_d == nsw_q) || (err_d && !err_q)) begin
               state_d = ST_WR_STOP;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_WR_STOP: if (wr_ack_s) state_d = ST_DONE; else state_d = state_q;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   // address/data of the write issued on entry to each write state
   always_comb begin
      addr_s = FR_MODE;
      data_s = BM_FR_MODE_RESET | mode_bits(mode_q);
      case (state_d)
         ST_WR_RST:  data_s = BM_FR_MODE_RESET;
         ST_WR_DEG:  begin addr_s = FR_DEGREE; data_s = {26'd0, deg_q};  end
         ST_WR_AMPL: begin addr_s = FR_AMPL;   data_s = {18'd0, ampl_q}; end
         ST_WR_RUN:  data_s = mode_bits(mode_q);
         default:    data_s = BM_FR_MODE_RESET | mode_bits(mode_q);
      endcase
      req_s = is_wr_state(state_d) && (state_d != state_q);
   end

   // sequencer registers and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         deg_q   <= 6'd0;
         ampl_q  <= 14'd0;
         mode_q  <= 3'd0;
         nsw_q   <= '0;
         sweep_q <= '0;
         strb_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         wdog_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         deg_q   <= deg_d;
         ampl_q  <= ampl_d;
         mode_q  <= mode_d;
         nsw_q   <= nsw_d;
         sweep_q <= sweep_d;
         strb_q  <= strb_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SEQ_TIMEOUT_EN
         wdog_q  <= wdog_d;
`endif
      end
   end

   sounder_cfg_writer #(.WR_GAP(WR_GAP)) u_writer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (req_s),
      .addr_i (addr_s),
      .data_i (data_s),
      .ack_o  (wr_ack_s),
      .cfg    (cfg)
   );
endmodule

// File: tb/tb_sounder_sequencer.sv
// Scoreboard bench for sounder_sequencer: expected config writes are queued at start and
// compared as strobes appear; sweep/done/err behaviour checked around each run.
module tb_sounder_sequencer;
   localparam int WR_GAP = 2;
   localparam int CNT_W  = 16;
`ifdef SEQ_TIMEOUT_EN
   localparam int TIMEOUT = 100;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i, abort_i, tx_strobe_i, rx_strobe_i;
   logic [5:0]       degree_i;
   logic [13:0]      ampl_i;
   logic [2:0]       mode_i;
   logic [CNT_W-1:0] nsweeps_i;
   logic             busy_o, done_o, err_o;
   logic [CNT_W-1:0] sweep_cnt_o;

   sounder_sequencer_if cfg_if ();

   sounder_sequencer #(
      .WR_GAP  (WR_GAP),
      .CNT_W   (CNT_W)
`ifdef SEQ_TIMEOUT_EN
     ,.TIMEOUT (TIMEOUT)
`endif
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .degree_i    (degree_i),
      .ampl_i      (ampl_i),
      .mode_i      (mode_i),
      .nsweeps_i   (nsweeps_i),
      .tx_strobe_i (tx_strobe_i),
      .rx_strobe_i (rx_strobe_i),
      .cfg         (cfg_if),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .sweep_cnt_o (sweep_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   logic [38:0] exp_q[$];
   int n_writes    = 0;
   int last_wr_cyc = 0;
   int run_id      = 0;
   int mon_run     = -1;
   int run_wr_idx  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // write monitor: pops the scoreboard on every config strobe
   always @(negedge clk) begin
      logic [38:0] e;
      if (cfg_if.s_strobe === 1'b1) begin
         if (mon_run != run_id) begin
            mon_run    = run_id;
            run_wr_idx = 0;
         end else begin
            run_wr_idx++;
         end
         if (run_wr_idx >= 1 && run_wr_idx <= 4) check("wr_spacing", 32'(cyc - last_wr_cyc), 32'(WR_GAP + 1));
         last_wr_cyc = cyc;
         n_writes++;
         check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", {25'd0, cfg_if.saddr}, {25'd0, e[38:32]});
            check("wr_data", cfg_if.sdata, e[31:0]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic [5:0] deg, input logic [13:0] ampl,
                            input logic [2:0] mode, input logic [CNT_W-1:0] nsw);
      logic [31:0] mb;
      mb = {28'd0, mode, 1'b0};
      run_id++;
      if (deg >= 6'd2 && deg <= 6'd16 && mode[1:0] != 2'b00) begin
         exp_q.push_back({7'd64, 32'd1});
         exp_q.push_back({7'd65, {26'd0, deg}});
         exp_q.push_back({7'd66, {18'd0, ampl}});
         exp_q.push_back({7'd64, mb | 32'd1});
         if (nsw != '0) exp_q.push_back({7'd64, mb});
         exp_q.push_back({7'd64, mb | 32'd1});
      end
      degree_i  = deg;
      ampl_i    = ampl;
      mode_i    = mode;
      nsweeps_i = nsw;
      start_i   = 1'b1;
      tick(1);
      start_i   = 1'b0;
   endtask

   task automatic wait_writes(input int target, input int budget);
      int k;
      k = 0;
      while (n_writes < target && k < budget) begin
         tick(1);
         k++;
      end
      check("wait_writes", 32'(n_writes >= target), 32'd1);
   endtask

   task automatic strobes(input bit use_rx, input int n);
      repeat (n) begin
         if (use_rx) rx_strobe_i = 1'b1;
         else        tx_strobe_i = 1'b1;
         tick(1);
      end
      rx_strobe_i = 1'b0;
      tx_strobe_i = 1'b0;
   endtask

   // leaves time at the negedge where done_o was seen; checks pulse width 1
   task automatic wait_done(input int budget);
      int k;
      bit seen;
      k = 0;
      seen = 1'b0;
      while (!seen && k < budget) begin
         @(negedge clk);
         if (done_o === 1'b1) seen = 1'b1;
         k++;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("busy_at_done", 32'(busy_o), 32'd0);
      @(negedge clk);
      check("done_pulse_len", 32'(done_o), 32'd0);
   endtask

   initial begin
      int base;
      rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; tx_strobe_i = 1'b0; rx_strobe_i = 1'b0;
      degree_i = 6'd0; ampl_i = 14'd0; mode_i = 3'd0; nsweeps_i = '0;
      tick(3);
      @(negedge clk);
      check("rst_outs", {busy_o, done_o, err_o, cfg_if.s_strobe, cfg_if.saddr, 16'(sweep_cnt_o)}, 32'd0);
      check("rst_sdata", cfg_if.sdata, 32'd0);
      tick(1);
      rst = 1'b0;
      tick(2);

      // 1: tx mode, two sweeps of degree 8
      base = n_writes;
      start_cmd(6'd8, 14'h1000, 3'b001, 16'd2);
      @(negedge clk);
      check("t1_busy", 32'(busy_o), 32'd1);
      wait_writes(base + 5, 100);
      tick(WR_GAP + 2);
      strobes(1'b0, 509);
      @(negedge clk);
      check("t1_sweep_509", 32'(sweep_cnt_o), 32'd1);
      check("t1_busy_run", 32'(busy_o), 32'd1);
      tick(1);
      strobes(1'b0, 1);
      wait_done(50);
      check("t1_sweeps", 32'(sweep_cnt_o), 32'd2);
      check("t1_nwrites", 32'(n_writes - base), 32'd6);
      check("t1_err", 32'(err_o), 32'd0);
      tick(2);

      // 2: rx|tx|lp counts rx strobes only
      base = n_writes;
      start_cmd(6'd8, 14'h0abc, 3'b111, 16'd1);
      wait_writes(base + 5, 100);
      tick(WR_GAP + 2);
      strobes(1'b0, 300);
      @(negedge clk);
      check("t2_tx_ignored", 32'(sweep_cnt_o), 32'd0);
      check("t2_still_busy", 32'(busy_o), 32'd1);
      tick(1);
      strobes(1'b1, 254);
      @(negedge clk);
      check("t2_sweep_254", 32'(sweep_cnt_o), 32'd0);
      tick(1);
      strobes(1'b1, 1);
      wait_done(50);
      check("t2_sweeps", 32'(sweep_cnt_o), 32'd1);
      tick(2);

      // 3: nsweeps=0 configures then stops
      base = n_writes;
      start_cmd(6'd5, 14'h2222, 3'b010, 16'd0);
      wait_done(100);
      check("t3_nwrites", 32'(n_writes - base), 32'd5);
      check("t3_sweeps", 32'(sweep_cnt_o), 32'd0);
      check("t3_q_empty", 32'(exp_q.size()), 32'd0);
      tick(2);

      // 4: illegal commands
      for (int i = 0; i < 3; i++) begin
         logic [5:0] d;
         logic [2:0] m;
         d = (i == 0) ? 6'd1 : ((i == 1) ? 6'd17 : 6'd8);
         m = (i == 2) ? 3'b100 : 3'b001;
         base = n_writes;
         start_cmd(d, 14'h0001, m, 16'd1);
         @(negedge clk);
         check("t4_done", 32'(done_o), 32'd1);
         check("t4_err", 32'(err_o), 32'd1);
         check("t4_busy", 32'(busy_o), 32'd0);
         @(negedge clk);
         check("t4_done_len", 32'(done_o), 32'd0);
         check("t4_err_sticky", 32'(err_o), 32'd1);
         check("t4_no_writes", 32'(n_writes - base), 32'd0);
         tick(1);
      end

      // boundary degrees: 16 clears err, 2 gives a 3-strobe sweep
      base = n_writes;
      start_cmd(6'd16, 14'h3fff, 3'b001, 16'd0);
      @(negedge clk);
      check("t4_err_cleared", 32'(err_o), 32'd0);
      wait_done(100);
      check("t4_deg16_writes", 32'(n_writes - base), 32'd5);
      tick(1);
      base = n_writes;
      start_cmd(6'd2, 14'h0002, 3'b001, 16'd1);
      wait_writes(base + 5, 100);
      tick(WR_GAP + 2);
      strobes(1'b0, 3);
      wait_done(50);
      check("t4_deg2_sweeps", 32'(sweep_cnt_o), 32'd1);
      tick(2);

      // 5: abort during AMPL write
      base = n_writes;
      start_cmd(6'd8, 14'h0555, 3'b001, 16'd1);
      wait_writes(base + 3, 100);
      exp_q.delete();
      exp_q.push_back({7'd64, 32'd3});
      abort_i = 1'b1;
      wait_done(100);
      abort_i = 1'b0;
      check("t5_nwrites", 32'(n_writes - base), 32'd4);
      check("t5_q_empty", 32'(exp_q.size()), 32'd0);
      tick(2);

      // 5b: asynchronous reset in RUN
      base = n_writes;
      start_cmd(6'd4, 14'h0111, 3'b001, 16'd3);
      wait_writes(base + 5, 100);
      tick(WR_GAP + 2);
      strobes(1'b0, 20);
      @(negedge clk);
      check("t5_sweep_pre", 32'(sweep_cnt_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_async_rst", {busy_o, done_o, err_o, cfg_if.s_strobe, cfg_if.saddr, 16'(sweep_cnt_o)}, 32'd0);
      check("t5_async_sdata", cfg_if.sdata, 32'd0);
      exp_q.delete();
      tick(2);
      rst = 1'b0;
      tick(2);

`ifdef SEQ_TIMEOUT_EN
      // 6: watchdog with no strobes in RUN
      begin
         int k;
         int run_wr;
         base = n_writes;
         start_cmd(6'd8, 14'h0fff, 3'b001, 16'd1);
         wait_writes(base + 5, 100);
         run_wr = last_wr_cyc;
         k = 0;
         while (err_o !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
         end
         check("t6_err", 32'(err_o), 32'd1);
         check("t6_err_time", 32'(cyc - run_wr), 32'(WR_GAP + 1 + TIMEOUT));
         wait_done(50);
         check("t6_nwrites", 32'(n_writes - base), 32'd6);
         check("t6_err_held", 32'(err_o), 32'd1);
      end
`endif

      check("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
